// File: rtl/uart_tx_scheduler.sv
// Round-robin byte scheduler feeding a single UART transmitter.
// Frames are 8N1-style: start bit, DATA_BITS LSB-first, one stop bit.
module uart_tx_scheduler #(
  parameter  int NUM_REQ   = 4,
  parameter  int DATA_BITS = 8,
  localparam int ID_W      = $clog2(NUM_REQ),
  localparam int CNT_W     = $clog2(DATA_BITS) + 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           baud_tick,
  output logic                           baud_start,
  output logic                           tx,
  output logic                           busy,
  output logic [ID_W-1:0]                grant_id
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t               state, state_n;
  logic [ID_W-1:0]      rr_ptr, rr_ptr_n;
  logic [ID_W-1:0]      winner;
  logic [ID_W-1:0]      grant_id_n;
  logic [DATA_BITS-1:0] shift_reg, shift_n;
  logic [DATA_BITS-1:0] sel_data;
  logic [CNT_W-1:0]     bit_cnt, bit_cnt_n;
  logic                 tx_n;
  logic                 accept;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);

  // Scan downward so the requester closest to rr_ptr wins last.
  always_comb begin
    logic [ID_W:0] sum;
    winner = '0;
    sum    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(NUM_REQ)) begin
        sum = sum - (ID_W+1)'(NUM_REQ);
      end
      if (req_valid[sum[ID_W-1:0]]) begin
        winner = sum[ID_W-1:0];
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        sel_data = req_data[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

  assign accept     = (state == IDLE) && (|req_valid) && !reset;
  assign req_ready  = accept ? (NUM_REQ'(1) << winner) : '0;
  assign baud_start = accept;
  assign busy       = (state != IDLE);

  always_comb begin
    state_n    = state;
    shift_n    = shift_reg;
    bit_cnt_n  = bit_cnt;
    tx_n       = tx;
    rr_ptr_n   = rr_ptr;
    grant_id_n = grant_id;
    unique case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (accept) begin
          state_n    = START;
          shift_n    = sel_data;
          bit_cnt_n  = '0;
          grant_id_n = winner;
          rr_ptr_n   = (winner == LAST_ID) ? '0 : winner + 1'b1;
          tx_n       = 1'b0;
        end
      end
      START: begin
        if (baud_tick) begin
          state_n   = DATA;
          bit_cnt_n = '0;
          tx_n      = shift_reg[0];
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (bit_cnt == LAST_BIT) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            shift_n   = shift_reg >> 1;
            bit_cnt_n = bit_cnt + 1'b1;
            tx_n      = shift_n[0];
          end
        end
      end
      STOP: begin
        tx_n = 1'b1;
        if (baud_tick) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      tx        <= 1'b1;
      rr_ptr    <= '0;
      grant_id  <= '0;
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else begin
      state     <= state_n;
      tx        <= tx_n;
      rr_ptr    <= rr_ptr_n;
      grant_id  <= grant_id_n;
      shift_reg <= shift_n;
      bit_cnt   <= bit_cnt_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: frame-level reference model with
// round-robin prediction, directed corner cases and random traffic.
module tb_uart_tx_scheduler;

  localparam int N = 4;
  localparam int W = 8;

  logic           clock;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           baud_tick;
  logic           baud_start;
  logic           tx;
  logic           busy;
  logic [1:0]     grant_id;

  int n_tests;
  int n_fail;
  int ptr;

  uart_tx_scheduler #(
    .NUM_REQ  (N),
    .DATA_BITS(W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .baud_tick (baud_tick),
    .baud_start(baud_start),
    .tx        (tx),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] get_byte(input int i);
    return 8'(req_data >> (i * W));
  endfunction

  task automatic set_byte(input int i, input logic [7:0] b);
    req_data = (req_data & ~(32'hFF << (i * W))) | (32'(b) << (i * W));
  endtask

  // Line level expected after k bit periods of a frame carrying d.
  function automatic logic fbit(input logic [7:0] d, input int k);
    logic [7:0] s;
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    s = d >> (k - 1);
    return s[0];
  endfunction

  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (p + k) % N;
      if (((m >> i) & 4'd1) != 4'd0) return i;
    end
    return -1;
  endfunction

  task automatic do_frame(input int gap, input int stall_at,
                          input int ticks, input bit keep,
                          input bit tick_acc);
    int w;
    logic [7:0] d;
    w = pick(req_valid, ptr);
    if (w < 0) w = 0;
    d = get_byte(w);
    if (tick_acc && gap < 2) gap = 2;
    baud_tick = tick_acc;
    #1;
    chk("ready", req_ready, 32'(4'(1) << w));
    chk("bstart", baud_start, 1);
    cyc;
    baud_tick = 1'b0;
    ptr = (w + 1) % N;
    if (!keep) req_valid = req_valid & ~(4'(1) << w);
    set_byte(w, 8'($urandom));
    #1;
    chk("bstart_pulse", baud_start, 0);
    chk("ready_off", req_ready, 0);
    chk("busy_on", busy, 1);
    chk("gid", grant_id, w);
    for (int t = 1; t <= ticks; t++) begin
      for (int g = 1; g < gap; g++) cyc;
      if (t == stall_at) begin
        repeat (100) cyc;
        chk("stall_busy", busy, 1);
      end
      chk("hold", tx, fbit(d, t - 1));
      baud_tick = 1'b1;
      cyc;
      baud_tick = 1'b0;
      if (t < 10) begin
        chk("bit", tx, fbit(d, t));
        if (t == 9) chk("stop_busy", busy, 1);
      end else begin
        chk("end_tx", tx, 1);
        chk("end_busy", busy, 0);
      end
    end
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    ptr       = 0;
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    baud_tick = 1'b0;
    repeat (3) cyc;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_gid", grant_id, 0);
    req_valid = 4'b0100;
    set_byte(2, 8'hA5);
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_bstart", baud_start, 0);
    cyc;
    reset = 1'b0;

    do_frame(16, 0, 10, 1'b0, 1'b0);
    chk("a5_gid", grant_id, 2);

    baud_tick = 1'b1;
    repeat (3) cyc;
    baud_tick = 1'b0;
    chk("idle_tick_tx", tx, 1);
    chk("idle_tick_busy", busy, 0);

    reset = 1'b1;
    cyc;
    reset = 1'b0;
    ptr = 0;
    req_valid = 4'hF;
    for (int i = 0; i < N; i++) set_byte(i, 8'(8'h11 * (i + 1)));
    for (int k = 0; k < 5; k++) begin
      do_frame($urandom_range(1, 3), 0, 10, 1'b1, k == 2);
      chk("rr_gid", grant_id, k % N);
    end

    req_valid = 4'b0001;
    do_frame(2, 0, 10, 1'b0, 1'b0);
    chk("skip_gid", grant_id, 0);
    req_valid = 4'b1011;
    do_frame(1, 0, 10, 1'b0, 1'b0);
    chk("skip_next", grant_id, 1);

    do_frame(3, 5, 10, 1'b0, 1'b0);
    chk("stall_gid", grant_id, 3);

    req_valid = 4'b0001;
    set_byte(0, 8'h3C);
    do_frame(4, 0, 3, 1'b0, 1'b0);
    reset = 1'b1;
    req_valid = 4'b1001;
    #1;
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_bstart", baud_start, 0);
    cyc;
    reset = 1'b0;
    ptr = 0;
    chk("abort_tx", tx, 1);
    chk("abort_busy", busy, 0);
    do_frame(2, 0, 10, 1'b0, 1'b0);
    chk("post_rst_gid", grant_id, 0);

    for (int f = 0; f < 25; f++) begin
      for (int i = 0; i < N; i++) begin
        if (((req_valid >> i) & 4'd1) == 4'd0 && ($urandom % 2) == 1) begin
          req_valid = req_valid | (4'(1) << i);
          set_byte(i, 8'($urandom));
        end
      end
      if (req_valid == '0) begin
        int j;
        j = $urandom_range(0, N - 1);
        req_valid = 4'(1) << j;
        set_byte(j, 8'($urandom));
      end
      do_frame($urandom_range(1, 4),
               (($urandom % 5) == 0) ? $urandom_range(1, 10) : 0,
               10, 1'b0, ($urandom % 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4, number of byte requesters (2..8).
REQ-002 Parameter DATA_BITS, default 8, bits per frame payload.
REQ-003 clock  input  1  clock; all state on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  NUM_REQ  per-requester byte valid; bit i belongs to requester i.
REQ-006 req_data  input  NUM_REQ*DATA_BITS  requester i byte in slice [i*DATA_BITS +: DATA_BITS].
REQ-007 req_ready  output  NUM_REQ  one-hot-or-zero accept strobe; transfer when req_valid[i] && req_ready[i].
REQ-008 baud_tick  input  1  one-cycle bit-period pulse from the shared baud rate generator.
REQ-009 baud_start  output  1  one-cycle pulse that restarts the baud generator's TX phase at frame start.
REQ-010 tx  output  1  serial line, idle high.
REQ-011 busy  output  1  high while a frame is in flight (any state other than IDLE).
REQ-012 grant_id  output  $clog2(NUM_REQ)  index of the requester whose byte is on the line or was last sent.

Function
REQ-013 FSM states: IDLE, START, DATA, STOP; frame = 1 start bit (0), DATA_BITS data bits LSB first, 1 stop bit (1).
REQ-014 Round-robin pointer rr_ptr: in IDLE, the winner is the first i with req_valid[i]=1 searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
REQ-015 req_ready is combinational: req_ready[winner]=1 only when state==IDLE and any req_valid is high; all other bits 0; all 0 outside IDLE.
REQ-016 On the accept cycle: latch req_data slice into shift register, grant_id<=winner, rr_ptr<=(winner+1) mod NUM_REQ, baud_start=1 (same cycle, combinational), state<=START.
REQ-017 baud_start is high only on accept cycles; never two consecutive cycles.
REQ-018 tx is registered: 1 in IDLE and STOP, 0 in START, shift_reg[0] in DATA.
REQ-019 baud_tick is ignored in IDLE and on the accept cycle itself.
REQ-020 START: on baud_tick go to DATA with bit counter=0, tx<=data bit 0.
REQ-021 DATA: on each baud_tick, if bit counter==DATA_BITS-1 go to STOP (tx<=1), else shift right, increment counter, tx<=next bit.
REQ-022 STOP: on baud_tick go to IDLE; the next accept can occur the cycle after (line high at least one full bit period plus one clock between frames).
REQ-023 Without baud_tick the FSM holds state and tx indefinitely.
REQ-024 req_valid deasserting on a non-granted requester has no effect; requesters SHALL hold valid and data until ready (protocol rule, not checked).
REQ-025 Changes on req_data after accept do not affect the frame in flight.
REQ-026 Bit counter width $clog2(DATA_BITS)+1; no wrap beyond DATA_BITS-1.

Reset
REQ-027 On reset: state=IDLE, tx=1, busy=0, req_ready=0, baud_start=0, grant_id=0, rr_ptr=0, shift register and bit counter 0.
REQ-028 Reset mid-frame aborts the frame; tx=1 the cycle after reset is sampled; the byte is not retried and no req_ready is issued while reset is high.

Verification
REQ-029 Single byte: req_valid[2]=1, data 0xA5, ticks every 16 clocks -> req_ready[2] one cycle, baud_start same cycle, tx sequence 0,1,0,1,0,0,1,0,1,1 per tick, grant_id=2, busy low after stop tick.
REQ-030 Round robin: all four valid continuously with distinct bytes -> grant order 0,1,2,3,0; each requester accepted exactly once per four frames.
REQ-031 Pointer skip: rr_ptr=1, only req_valid[0] high -> requester 0 granted; next grant search starts at 1.
REQ-032 Tick stall: withhold baud_tick 100 cycles in DATA -> tx and state unchanged; resumes correctly.
REQ-033 Reset after 3rd data bit -> tx=1, busy=0 next cycle; pending valid requester accepted in first IDLE cycle after reset deasserts, starting search at 0.
REQ-034 Tick coincident with accept cycle -> ignored; start bit lasts until the following tick.
